trig_gen_n: RTL and testbench

TRIG_GEN_N -- requirements
Module: trig_gen_n

---
 rtl/trig_pkg.sv | 23 ++
 rtl/trig_popcount.sv | 38 +++
 rtl/trig_gen_n.sv | 217 +++++++++++++++++++++
 tb/tb_trig_gen_n.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// ---------------------------------------------------------------------------
// trig_pkg
// Shared encodings for the trigger generator:
//   trig_mode_e  - trigger source selection (external, cyclic, masked-OR,
//                  multiplicity)
//   trig_state_e - pulse FSM states (IDLE, FIRE, HOLD)
// ---------------------------------------------------------------------------
package trig_pkg;

    typedef enum logic [1:0] {
        MODE_EXT  = 2'b00,
        MODE_CYC  = 2'b01,
        MODE_OR   = 2'b10,
        MODE_MULT = 2'b11
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FIRE = 2'b01,
        ST_HOLD = 2'b10
    } trig_state_e;

endpackage

// File: rtl/trig_popcount.sv
// ---------------------------------------------------------------------------
// trig_popcount
// Registered population count of an NCH-bit vector.
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous active-high reset (clears the count)
//   i_bits  - input vector
//   o_count - number of set bits in i_bits, one clock later
// ---------------------------------------------------------------------------
module trig_popcount #(
    parameter int NCH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NCH-1:0]             i_bits,
    output logic [$clog2(NCH+1)-1:0]   o_count
);

    localparam int PCW = $clog2(NCH+1);

    logic [PCW-1:0] w_sum;
    logic [PCW-1:0] r_count;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = w_sum + PCW'(i_bits[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_count <= '0;
        else       r_count <= w_sum;
    end

    assign o_count = r_count;

endmodule

// File: rtl/trig_gen_n.sv
// ---------------------------------------------------------------------------
// trig_gen_n
// Trigger generator: selects a candidate source, detects its rising edge,
// and issues a PW-clock trigger pulse followed by a holdoff dead time.
// Input-to-trig_out latency is 2 clocks in every mode.
// Optional feature macro: TRIG_GEN_PRESCALE_EN adds input prescale[7:0];
// only every (prescale+1)th non-rejected candidate then fires.
// Ports:
//   init_clk      - clock
//   reset_i       - synchronous active-high reset
//   trigger_stun  - drop new candidates (uncounted) while high
//   trig_mode     - 00 external, 01 cyclic, 10 masked-OR, 11 multiplicity
//   cyc_period    - cyclic period exponent (bit min(cyc_period+4,31))
//   mult_thr      - multiplicity threshold (0 = never)
//   chan_mask     - per-channel enable for modes 10/11
//   overth        - per-channel over-threshold flags
//   trig_in       - external trigger
//   holdoff       - dead clocks after each pulse (sampled on FIRE entry)
//   prescale      - (TRIG_GEN_PRESCALE_EN only) prescale factor minus one
//   trig_out      - trigger pulse, high in FIRE
//   cyctrig_pls   - cyclic square wave
//   trig_cnt      - issued triggers (wrapping)
//   lost_cnt      - candidates rejected while busy (saturating)
//   busy          - FSM in FIRE or HOLD
//   state_dbg     - current FSM state (trig_state_e encoding)
// ---------------------------------------------------------------------------
module trig_gen_n
    import trig_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int PW        = 10,
    parameter int RST_BLOCK = 256,
    parameter int HW        = 8
) (
    input  logic                       init_clk,
    input  logic                       reset_i,
    input  logic                       trigger_stun,
    input  logic [1:0]                 trig_mode,
    input  logic [4:0]                 cyc_period,
    input  logic [$clog2(NCH+1)-1:0]   mult_thr,
    input  logic [NCH-1:0]             chan_mask,
    input  logic [NCH-1:0]             overth,
    input  logic                       trig_in,
    input  logic [HW-1:0]              holdoff,
`ifdef TRIG_GEN_PRESCALE_EN
    input  logic [7:0]                 prescale,
`endif
    output logic                       trig_out,
    output logic                       cyctrig_pls,
    output logic [31:0]                trig_cnt,
    output logic [15:0]                lost_cnt,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int PCW  = $clog2(NCH+1);
    localparam int CNTW = (HW > 8) ? HW : 8;

    // Input pipeline: stage 1 registers raw inputs, stage 2 aligns the
    // external and cyclic sources with the registered popcount.
    logic [NCH-1:0] r_masked;
    logic           r_trig_s1, r_trig_s2;
    logic           r_cyc_s1, r_cyc_s2;
    logic [PCW-1:0] w_pop;

    logic [31:0]    r_free;
    logic [31:0]    r_blk;
    logic [1:0]     r_mode_q;
    logic           r_lvl_prev;
    logic [31:0]    r_trig_cnt;
    logic [15:0]    r_lost;

    logic [4:0]     w_cyc_sel;
    logic           w_cyc_bit;
    logic           w_lvl;
    logic           w_mode_chg;
    logic           w_cand;
    logic           w_live;
    logic           w_reject;
    logic           w_accept_pre;
    logic           w_fire;

    trig_state_e    r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [CNTW-1:0] r_hold, w_hold_nxt;

    trig_popcount #(.NCH(NCH)) u_pop (
        .i_clk   (init_clk),
        .i_rst   (reset_i),
        .i_bits  (r_masked),
        .o_count (w_pop)
    );

    always_comb begin
        w_cyc_sel = (cyc_period >= 5'd28) ? 5'd31 : cyc_period + 5'd4;
    end
    assign w_cyc_bit = r_free[w_cyc_sel];

    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            r_masked  <= '0;
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_cyc_s1  <= 1'b0;
            r_cyc_s2  <= 1'b0;
            r_free    <= '0;
        end else begin
            r_masked  <= overth & chan_mask;
            r_trig_s1 <= trig_in;
            r_trig_s2 <= r_trig_s1;
            r_cyc_s1  <= w_cyc_bit;
            r_cyc_s2  <= r_cyc_s1;
            r_free    <= r_free + 32'd1;
        end
    end

    always_comb begin
        w_lvl = 1'b0;
        case (trig_mode_e'(trig_mode))
            MODE_EXT:  w_lvl = r_trig_s2;
            MODE_CYC:  w_lvl = r_cyc_s2;
            MODE_OR:   w_lvl = (w_pop != '0);
            MODE_MULT: w_lvl = (mult_thr != '0) && (w_pop >= mult_thr);
            default:   w_lvl = 1'b0;
        endcase
    end

    // A mode change clears the edge history and suppresses a candidate in
    // that same clock, so a level already high in the new mode is seen as a
    // fresh rising edge one clock later.
    assign w_mode_chg   = (trig_mode != r_mode_q);
    assign w_cand       = w_lvl && !r_lvl_prev && !w_mode_chg;
    assign w_live       = w_cand && !trigger_stun && (r_blk == '0);
    assign w_reject     = w_live && (r_state != ST_IDLE);
    assign w_accept_pre = w_live && (r_state == ST_IDLE);

`ifdef TRIG_GEN_PRESCALE_EN
    logic [7:0] r_ps;
    always_ff @(posedge init_clk) begin
        if (reset_i || w_mode_chg) r_ps <= '0;
        else if (w_accept_pre)     r_ps <= (r_ps >= prescale) ? 8'd0 : r_ps + 8'd1;
    end
    // >= rather than == so a lowered prescale cannot strand the counter.
    assign w_fire = w_accept_pre && (r_ps >= prescale);
`else
    assign w_fire = w_accept_pre;
`endif

    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            r_blk      <= 32'(RST_BLOCK);
            r_mode_q   <= trig_mode;
            r_lvl_prev <= 1'b0;
            r_trig_cnt <= '0;
            r_lost     <= '0;
        end else begin
            if (r_blk != '0) r_blk <= r_blk - 32'd1;
            r_mode_q   <= trig_mode;
            r_lvl_prev <= w_mode_chg ? 1'b0 : w_lvl;
            if (w_fire) r_trig_cnt <= r_trig_cnt + 32'd1;
            if (w_reject && (r_lost != 16'hFFFF)) r_lost <= r_lost + 16'd1;
        end
    end

    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // r_cnt counts down the remaining clocks of FIRE, then of HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt = ST_FIRE;
                    w_cnt_nxt   = CNTW'(PW - 1);
                    w_hold_nxt  = CNTW'(holdoff);
                end
            end
            ST_FIRE: begin
                if (r_cnt == '0) begin
                    if (r_hold != '0) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = r_hold - CNTW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt - CNTW'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign trig_out    = (r_state == ST_FIRE);
    assign busy        = (r_state != ST_IDLE);
    assign state_dbg   = r_state;
    assign cyctrig_pls = w_cyc_bit;
    assign trig_cnt    = r_trig_cnt;
    assign lost_cnt    = r_lost;

endmodule

// File: tb/tb_trig_gen_n.sv
// ---------------------------------------------------------------------------
// tb_trig_gen_n
// Bench for trig_gen_n: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against an edge-indexed model.
// Honours TRIG_GEN_PRESCALE_EN when defined.
// ---------------------------------------------------------------------------
module tb_trig_gen_n;

  localparam int NCH       = 8;
  localparam int PW        = 10;
  localparam int RST_BLOCK = 256;
  localparam int HW        = 8;
  localparam int PCW       = $clog2(NCH+1);

  // clock / reset / stimulus signals
  logic             init_clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             trigger_stun = 1'b0;
  logic [1:0]       trig_mode = 2'b00;
  logic [4:0]       cyc_period = 5'd0;
  logic [PCW-1:0]   mult_thr = '0;
  logic [NCH-1:0]   chan_mask = '0;
  logic [NCH-1:0]   overth = '0;
  logic             trig_in = 1'b0;
  logic [HW-1:0]    holdoff = '0;
`ifdef TRIG_GEN_PRESCALE_EN
  logic [7:0]       prescale = 8'd0;
`endif
  logic             trig_out, cyctrig_pls, busy;
  logic [31:0]      trig_cnt;
  logic [15:0]      lost_cnt;
  logic [1:0]       state_dbg;

  always #5 init_clk = ~init_clk;

  trig_gen_n #(.NCH(NCH), .PW(PW), .RST_BLOCK(RST_BLOCK), .HW(HW)) dut (
    .init_clk     (init_clk),
    .reset_i      (reset_i),
    .trigger_stun (trigger_stun),
    .trig_mode    (trig_mode),
    .cyc_period   (cyc_period),
    .mult_thr     (mult_thr),
    .chan_mask    (chan_mask),
    .overth       (overth),
    .trig_in      (trig_in),
    .holdoff      (holdoff),
`ifdef TRIG_GEN_PRESCALE_EN
    .prescale     (prescale),
`endif
    .trig_out     (trig_out),
    .cyctrig_pls  (cyctrig_pls),
    .trig_cnt     (trig_cnt),
    .lost_cnt     (lost_cnt),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rel     = -1;   // edges since reset released (0 = first free edge)

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at rel %0d", name, act, exp, rel);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model, indexed by absolute edge number.
  // The candidate judged at edge e uses the inputs sampled at edge e-2.
  // A trigger fired at edge F keeps trig_out high after edges F..F+PW-1 and
  // busy high until edge F+PW+holdoff-1.
  // -------------------------------------------------------------------------
  logic        m_on = 1'b0;
  int          m_e = 0;
  logic [31:0] m_free = '0;
  int          m_blk_last = 0;
  logic        m_fired = 1'b0;
  int          m_F = 0;
  int          m_busy_end = 0;
  logic [31:0] m_trig_cnt = '0;
  int          m_lost = 0;
  int          m_n_ok = 0;
  logic        m_prev_lvl = 1'b0;
  logic [1:0]  m_prev_mode = 2'b00;
  logic        h_trig[2];
  int          h_pop[2];
  logic        h_cyc[2];

  function automatic logic cyc_bit(input logic [31:0] cnt, input logic [4:0] cp);
    int idx;
    idx = int'(cp) + 4;
    if (idx > 31) idx = 31;
    return cnt[idx];
  endfunction

  always @(posedge init_clk) begin
    logic lvl, cand, live, idle, mchg, fire;
    int   ps;
    m_e++;
    if (reset_i) begin
      m_on = 1'b1;
      rel = -1;
      m_free = '0;
      m_blk_last = m_e + RST_BLOCK;
      m_fired = 1'b0;
      m_trig_cnt = '0;
      m_lost = 0;
      m_n_ok = 0;
      m_prev_lvl = 1'b0;
      m_prev_mode = trig_mode;
      for (int i = 0; i < 2; i++) begin
        h_trig[i] = 1'b0; h_pop[i] = 0; h_cyc[i] = 1'b0;
      end
    end else begin
      rel++;
      case (trig_mode)
        2'b00:   lvl = h_trig[1];
        2'b01:   lvl = h_cyc[1];
        2'b10:   lvl = (h_pop[1] >= 1);
        default: lvl = (mult_thr != 0) && (h_pop[1] >= int'(mult_thr));
      endcase
      mchg = (trig_mode != m_prev_mode);
      cand = lvl && !m_prev_lvl && !mchg;
      m_prev_lvl = mchg ? 1'b0 : lvl;
      m_prev_mode = trig_mode;
      if (mchg) m_n_ok = 0;
      live = cand && !trigger_stun && (m_e > m_blk_last);
      idle = !m_fired || (m_e - 1 >= m_busy_end);
      if (live && !idle && m_lost < 65535) m_lost++;
      if (live && idle) begin
`ifdef TRIG_GEN_PRESCALE_EN
        ps = int'(prescale);
`else
        ps = 0;
`endif
        fire = ((m_n_ok % (ps + 1)) == ps);
        m_n_ok++;
        if (fire) begin
          m_fired = 1'b1;
          m_F = m_e;
          m_busy_end = m_e + PW + int'(holdoff);
          m_trig_cnt++;
        end
      end
      h_trig[1] = h_trig[0]; h_pop[1] = h_pop[0]; h_cyc[1] = h_cyc[0];
      h_trig[0] = trig_in;
      h_pop[0]  = $countones(overth & chan_mask);
      h_cyc[0]  = cyc_bit(m_free, cyc_period);
      m_free = m_free + 32'd1;
    end
  end

  // Scoreboard compare: every cycle once the model is live.
  always @(negedge init_clk) begin
    if (m_on) begin
      chk("trig_out", trig_out, m_fired && (m_e < m_F + PW));
      chk("busy", busy, m_fired && (m_e < m_busy_end));
      chk("cyctrig_pls", cyctrig_pls, cyc_bit(m_free, cyc_period));
      chk("trig_cnt", trig_cnt, m_trig_cnt);
      chk("lost_cnt", lost_cnt, m_lost);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge init_clk);
    #1;
  endtask

  task automatic go_rel(input int c);
    int g = 0;
    while (rel < c && g < 3000) begin
      tick();
      g++;
    end
    chk("go_rel", rel, c);
  endtask

  task automatic pulse(input int c);
    go_rel(c - 1);
    trig_in = 1'b1;
    go_rel(c);
    trig_in = 1'b0;
  endtask

  initial begin
    int hi, first, nr, prev;
    int rises[3];

    // reset state
    reset_i = 1'b1;
    repeat (3) tick();
    chk("rst_trig_out", trig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig_cnt", trig_cnt, 0);
    chk("rst_lost_cnt", lost_cnt, 0);
    chk("rst_cyctrig", cyctrig_pls, 0);
    reset_i = 1'b0;

    // reset block: pulse at 100 is swallowed
    pulse(100);
    hi = 0;
    repeat (15) begin tick(); if (trig_out) hi++; end
    chk("blk_no_fire", hi, 0);
    chk("blk_lost", lost_cnt, 0);

    // mode 00 edge at 300 -> trig_out 302..311
    go_rel(299);
    trig_in = 1'b1;
    first = -1; hi = 0;
    repeat (25) begin
      tick();
      if (trig_out) begin if (first < 0) first = rel; hi++; end
    end
    chk("ext_first", first, 302);
    chk("ext_width", hi, 10);
    chk("ext_cnt", trig_cnt, 1);
    trig_in = 1'b0;

    // holdoff 5: edge +8 rejected, edge +16 fires
    holdoff = 8'd5;
    pulse(400);
    pulse(408);
    go_rel(440);
    chk("hold_lost", lost_cnt, 1);
    chk("hold_cnt", trig_cnt, 2);
    pulse(500);
    pulse(516);
    go_rel(517);
    chk("hold_idle_gap", trig_out, 0);
    go_rel(518);
    chk("hold_refire", trig_out, 1);
    go_rel(540);
    chk("hold_cnt2", trig_cnt, 4);
    chk("hold_lost2", lost_cnt, 1);

    // multiplicity, thr 3, mask 0F
    go_rel(590);
    trig_mode = 2'b11; mult_thr = PCW'(3); chan_mask = 8'h0F; holdoff = '0; overth = '0;
    go_rel(619); overth = 8'h07;
    go_rel(621); chk("mult_lat_lo", trig_out, 0);
    go_rel(622); chk("mult_lat_hi", trig_out, 1);
    go_rel(629); overth = '0;
    go_rel(640); chk("mult_fire", trig_cnt, 5);
    go_rel(659); overth = 8'hF3;
    go_rel(669); overth = '0;
    go_rel(679); overth = 8'hF1;
    go_rel(689); overth = '0;
    go_rel(700); chk("mult_below", trig_cnt, 5);
    go_rel(709); mult_thr = '0; overth = 8'hFF;
    go_rel(719); overth = '0;
    go_rel(730); chk("mult_thr0", trig_cnt, 5);

    // masked OR
    go_rel(740); trig_mode = 2'b10;
    go_rel(759); overth = 8'h10;
    go_rel(769); overth = '0;
    go_rel(779); overth = 8'h02;
    go_rel(789); overth = '0;
    go_rel(800); chk("or_mask", trig_cnt, 6);

    // cyclic, period 32, then holdoff 40 -> period 64
    go_rel(810); trig_mode = 2'b01; cyc_period = 5'd0; holdoff = '0;
    nr = 0; prev = 0;
    for (int i = 0; i < 300 && nr < 3; i++) begin
      tick();
      if (trig_out && !prev) begin rises[nr] = rel; nr++; end
      prev = trig_out;
    end
    chk("cyc_phase", rises[0] % 32, 18);
    chk("cyc_per_a", rises[1] - rises[0], 32);
    chk("cyc_per_b", rises[2] - rises[1], 32);
    holdoff = 8'd40;
    nr = 0;
    for (int i = 0; i < 400 && nr < 3; i++) begin
      tick();
      if (trig_out && !prev) begin rises[nr] = rel; nr++; end
      prev = trig_out;
    end
    chk("cyc_hold_a", rises[1] - rises[0], 64);
    chk("cyc_hold_b", rises[2] - rises[1], 64);
    chk("cyc_hold_lost", lost_cnt, 3);

    // reset mid-pulse
    chk("mid_pre", trig_out, 1);
    reset_i = 1'b1;
    tick();
    chk("mid_drop", trig_out, 0);
    chk("mid_busy", busy, 0);
    trig_mode = 2'b00; holdoff = '0; cyc_period = 5'd0;
`ifdef TRIG_GEN_PRESCALE_EN
    prescale = 8'd3;
`endif
    tick();
    reset_i = 1'b0;

    // 8 spaced candidates
    for (int k = 0; k < 8; k++) pulse(300 + 20 * k);
    go_rel(480);
`ifdef TRIG_GEN_PRESCALE_EN
    chk("prescale_cnt", trig_cnt, 2);
`else
    chk("noprescale_cnt", trig_cnt, 8);
`endif

    // randomized phase
    for (int i = 0; i < 5000; i++) begin
      tick();
      reset_i      = ($urandom_range(0, 1499) == 0);
      trigger_stun = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) trig_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)  cyc_period = 5'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0)  mult_thr = PCW'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0)  chan_mask = NCH'($urandom);
      overth  = NCH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
      holdoff = HW'($urandom_range(0, 12));
    end
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
